// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO control slave and the autonomous poll master.
package gpio_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_RADDR = 3'd2,
        ST_RDATA = 3'd3,
        ST_WRITE = 3'd4,
        ST_BRESP = 3'd5
    } poll_state_e;

    localparam logic [1:0] RESP_OKAY       = 2'b00;
    localparam logic [3:0] LED_ADDR_DEF    = 4'h0;
    localparam logic [3:0] SWITCH_ADDR_DEF = 4'h4;

endpackage

// File: rtl/gpio_poll_timer.sv
// Loadable down-counter that stops at zero and flags it.
module gpio_poll_timer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = load_val_i;
        else if (dec_i && count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/gpio_poll_master.sv
// AXI4-Lite master that polls the switch register and mirrors changes to the LEDs.
module gpio_poll_master
    import gpio_ctrl_pkg::*;
#(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
    parameter int unsigned SWITCH_WIDTH       = 8,
    parameter int unsigned POLL_CYCLES        = 1000,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] LED_ADDR    = LED_ADDR_DEF,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] SWITCH_ADDR = SWITCH_ADDR_DEF
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          enable,
    input  logic                          invert,
    output logic                          busy,
    output logic                          err,
    output logic [SWITCH_WIDTH-1:0]       last_sw,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    // Timer only ever holds POLL_CYCLES-1, so clog2 bits suffice (min 1).
    localparam int unsigned TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_RELOAD = TW'(POLL_CYCLES - 1);

    poll_state_e             state_q, state_d;
    logic                    arvalid_q, arvalid_d, rready_q, rready_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                    bready_q, bready_d, err_q, err_d, first_q, first_d;
    logic [SWITCH_WIDTH-1:0] sw_q, sw_d, led_q, led_d, last_sw_q, last_sw_d;
    logic [SWITCH_WIDTH-1:0] rd_sw;
    logic                    aw_done, w_done, tmr_zero;
    logic                    unused_rdata;

    assign rd_sw        = M_AXI_RDATA[SWITCH_WIDTH-1:0];
    assign unused_rdata = ^M_AXI_RDATA[C_M_AXI_DATA_WIDTH-1:SWITCH_WIDTH];

    // Reloading in every non-WAIT state guarantees a full period on each WAIT entry.
    gpio_poll_timer #(.WIDTH(TW)) u_timer (
        .clk_i      (M_AXI_ACLK),
        .rst_ni     (M_AXI_ARESETN),
        .load_i     (state_q != ST_WAIT),
        .load_val_i (TMR_RELOAD),
        .dec_i      (state_q == ST_WAIT),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        err_d     = err_q;
        first_d   = first_q;
        sw_d      = sw_q;
        led_d     = led_q;
        last_sw_d = last_sw_q;
        aw_done   = !awvalid_q || M_AXI_AWREADY;
        w_done    = !wvalid_q || M_AXI_WREADY;
        case (state_q)
            ST_IDLE: begin
                first_d = 1'b1;
                if (enable) state_d = ST_WAIT;
                else        err_d   = 1'b0;
            end
            ST_WAIT: begin
                if (tmr_zero) begin
                    if (enable) begin
                        state_d   = ST_RADDR;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    state_d  = ST_WAIT;
                    if (M_AXI_RRESP != RESP_OKAY) begin
                        err_d = 1'b1;
                    end else begin
                        sw_d = rd_sw;
                        if (first_q || rd_sw != last_sw_q) begin
                            state_d   = ST_WRITE;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                            led_d     = invert ? ~rd_sw : rd_sw;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_BRESP;
                end
            end
            ST_BRESP: begin
                if (M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    state_d  = ST_WAIT;
                    if (M_AXI_BRESP == RESP_OKAY) begin
                        last_sw_d = sw_q;
                        first_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= ST_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            err_q     <= 1'b0;
            first_q   <= 1'b1;
            sw_q      <= '0;
            led_q     <= '0;
            last_sw_q <= '0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            err_q     <= err_d;
            first_q   <= first_d;
            sw_q      <= sw_d;
            led_q     <= led_d;
            last_sw_q <= last_sw_d;
        end
    end

    assign busy          = (state_q == ST_RADDR) || (state_q == ST_RDATA) ||
                           (state_q == ST_WRITE) || (state_q == ST_BRESP);
    assign err           = err_q;
    assign last_sw       = last_sw_q;
    assign M_AXI_AWADDR  = LED_ADDR;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = {{(C_M_AXI_DATA_WIDTH-SWITCH_WIDTH){1'b0}}, led_q};
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = SWITCH_ADDR;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
